timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be asynchronous and active-low.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the rising-edge system clock.
REQ-003 The port clearn SHALL be an input, 1 bit wide, and SHALL be the asynchronous active-low reset.
REQ-004 The port D SHALL be an input, 4 bits wide, carrying the BCD digit from the keypad encoder.
REQ-005 The port loadn SHALL be an input, 1 bit wide, and SHALL be low while a keypad key is held.
REQ-006 The port pgt_1hz SHALL be an input, 1 bit wide, carrying the 1 Hz time base; only its rising edges SHALL be significant.
REQ-007 The ports startn and stopn SHALL be inputs, 1 bit each, debounced and active-low, with action taken on the falling edge.
REQ-008 The port door_closed SHALL be an input, 1 bit wide, and SHALL be high when the door is shut.
REQ-009 The port enablen SHALL be an output, 1 bit wide, and SHALL be low to enable keypad entry.
REQ-010 The port mag_on SHALL be an output, 1 bit wide, and SHALL drive the magnetron.
REQ-011 The ports min_bcd, sec_tens and sec_ones SHALL be outputs, 4 bits each, holding the BCD time M:SS.
REQ-012 The port done SHALL be an output, 1 bit wide, and SHALL be high in the DONE state.
REQ-013 The port beep SHALL be an output, 1 bit wide, and SHALL be the alarm drive.

Function
REQ-014 The block SHALL implement the states IDLE, SETTING, COOKING, PAUSED and DONE.
REQ-015 All edge detectors SHALL use registered copies of their input, so each action fires one cycle after the input edge.
REQ-016 A loadn falling edge in IDLE or SETTING SHALL shift the time left: min<-sec_tens, sec_tens<-sec_ones, sec_ones<-D. The state SHALL become SETTING.
REQ-017 A key SHALL be ignored if D>9 or if the shifted sec_tens would exceed 5.
REQ-018 enablen SHALL be low only in IDLE and SETTING; keys in other states SHALL be ignored, except as stated in REQ-024.
REQ-019 A start in SETTING or PAUSED with door_closed=1 and time not 0:00 SHALL enter COOKING. A start under any other condition SHALL be ignored.
REQ-020 In COOKING, each pgt_1hz rising edge SHALL decrement the time by 1 s. Borrow rules: sec_ones 0->9; sec_tens 0->5; min decrements.
REQ-021 A decrement that produces 0:00 SHALL move the state to DONE on the same update.
REQ-022 door_closed=0 in COOKING SHALL move the state to PAUSED within one cycle. A stop in COOKING SHALL also move the state to PAUSED.
REQ-023 A stop in SETTING or PAUSED SHALL clear the time to 0:00 and move the state to IDLE.
REQ-024 A stop or any key in DONE SHALL move the state to IDLE, leaving the time at 0:00.
REQ-025 mag_on SHALL equal (state==COOKING && door_closed); it SHALL be combinationally gated by the door.
REQ-026 Priority for simultaneous events in COOKING SHALL be: door open > stop > tick. A tick coincident with a higher-priority event SHALL NOT decrement.
REQ-027 Priority for simultaneous events in SETTING and PAUSED SHALL be: stop > start > key.

Reset
REQ-028 clearn low SHALL asynchronously force IDLE, time 0:00, mag_on=0, done=0, beep=0, enablen=0, and all edge-detector registers to their inactive level.
REQ-029 A reset asserted mid-cook SHALL drop mag_on immediately, with no wait for a clock edge.

Configuration
REQ-030 When DONE_BEEP_EN is defined, beep SHALL be high for exactly 3 pgt_1hz rising edges after entry to DONE, and the third edge SHALL also return the state to IDLE.
REQ-031 When DONE_BEEP_EN is undefined, beep SHALL be tied 0 and DONE SHALL persist until a stop or a key.

Structure
REQ-032 The package timer_pkg SHALL hold the state enumeration, the BCD limits (9, 5), the beep count (3) and the 4-bit BCD digit type.
REQ-033 The sub-module bcd_countdown SHALL perform the 3-digit load/shift/decrement with borrow and a zero flag; timer_ctrl SHALL hold the FSM and the edge detectors.

Verification
REQ-034 Keys 1, 3, 0, then start with the door closed, then 5 ticks: the bench SHALL show time 1:30 -> 1:25, with mag_on=1 throughout.
REQ-035 Time 1:00 and 1 tick: the bench SHALL show 0:59. Time 0:01 and 1 tick: the bench SHALL show 0:00, done=1 and mag_on=0.
REQ-036 Door opened at 0:45 with a simultaneous tick: the bench SHALL show PAUSED, time held at 0:45 and mag_on=0 in the same cycle; after the door closes and start, cooking SHALL resume.
REQ-037 In SETTING, keys 7 then 8: the bench SHALL show 0:78 rejected, so the time stays 0:07; then stop SHALL give IDLE at 0:00.
REQ-038 With DONE_BEEP_EN defined, reaching 0:00 SHALL give beep=1 for 3 ticks followed by IDLE. With it undefined, beep SHALL stay 0 and DONE SHALL hold until stop.
REQ-039 clearn pulsed low mid-cook at 2:10 SHALL give mag_on=0 asynchronously, time 0:00 and IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave cook timer (timer_ctrl and bcd_countdown).
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTING = 3'd1,
    ST_COOKING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam bcd_t       BCD_ONES_MAX = 4'd9;
  localparam bcd_t       BCD_TENS_MAX = 4'd5;
  localparam logic [1:0] BEEP_COUNT   = 2'd3;

  function automatic logic bcd_valid(input bcd_t d);
    return d <= BCD_ONES_MAX;
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Three-digit M:SS BCD register: clear, keypad shift-in, and 1 s decrement with borrow.
module bcd_countdown
  import timer_pkg::*;
(
  input  logic clk,
  input  logic clearn,
  input  logic clr,
  input  logic shift,
  input  bcd_t d,
  input  logic dec,
  output bcd_t min_o,
  output bcd_t tens_o,
  output bcd_t ones_o,
  output logic zero,
  output logic one_left
);

  bcd_t min_q, min_d;
  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;

  always_comb begin
    min_d  = min_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      min_d  = 4'd0;
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (shift) begin
      min_d  = tens_q;
      tens_d = ones_q;
      ones_d = d;
    end else if (dec && !zero) begin
      // Borrow ripples ones -> tens -> minutes; zero never decrements.
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else begin
        ones_d = BCD_ONES_MAX;
        if (tens_q != 4'd0) begin
          tens_d = tens_q - 4'd1;
        end else begin
          tens_d = BCD_TENS_MAX;
          min_d  = min_q - 4'd1;
        end
      end
    end else begin
      min_d  = min_q;
      tens_d = tens_q;
      ones_d = ones_q;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      min_q  <= 4'd0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      min_q  <= min_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign min_o    = min_q;
  assign tens_o   = tens_q;
  assign ones_o   = ones_q;
  assign zero     = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign one_left = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

endmodule

// File: rtl/timer_ctrl.sv
// Microwave cook timer: keypad entry, countdown control and door interlock.
// Optional DONE_BEEP_EN: alarm for three 1 Hz edges on DONE, then automatic return to IDLE.
module timer_ctrl
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic       mag_on,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       done,
  output logic       beep
);

  // Event bits: all idle high (pgt_1hz is inverted) so one falling-edge test serves all.
  localparam int EV_KEY   = 3;
  localparam int EV_START = 2;
  localparam int EV_STOP  = 1;
  localparam int EV_TICK  = 0;

  logic [3:0] samp_q, samp_d, prev_q, prev_d;
  bcd_t       d_q, d_d;
  state_e     state_q, state_d;
  logic       key_fall, start_fall, stop_fall, tick_rise;
  logic       key_ok, start_ok, beep_last;
  logic       cnt_clr, cnt_shift, cnt_dec, cnt_zero, cnt_one_left;

  always_comb begin
    samp_d = {loadn, startn, stopn, ~pgt_1hz};
    prev_d = samp_q;
    d_d    = D;
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      samp_q  <= 4'b1111;
      prev_q  <= 4'b1111;
      d_q     <= 4'd0;
      state_q <= ST_IDLE;
    end else begin
      samp_q  <= samp_d;
      prev_q  <= prev_d;
      d_q     <= d_d;
      state_q <= state_d;
    end
  end

  assign key_fall   = prev_q[EV_KEY]   & ~samp_q[EV_KEY];
  assign start_fall = prev_q[EV_START] & ~samp_q[EV_START];
  assign stop_fall  = prev_q[EV_STOP]  & ~samp_q[EV_STOP];
  assign tick_rise  = prev_q[EV_TICK]  & ~samp_q[EV_TICK];

  // Current sec_ones becomes sec_tens after the shift, so it must stay within 0..5.
  assign key_ok   = bcd_valid(d_q) && (sec_ones <= BCD_TENS_MAX);
  assign start_ok = door_closed && !cnt_zero;

`ifdef DONE_BEEP_EN
  logic [1:0] beep_cnt_q, beep_cnt_d;

  always_comb begin
    if (state_q != ST_DONE) begin
      beep_cnt_d = 2'd0;
    end else if (tick_rise) begin
      beep_cnt_d = beep_cnt_q + 2'd1;
    end else begin
      beep_cnt_d = beep_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      beep_cnt_q <= 2'd0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep_last = (beep_cnt_q == (BEEP_COUNT - 2'd1));
`else
  assign beep_last = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_shift = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_fall && key_ok) begin
          cnt_shift = 1'b1;
          state_d   = ST_SETTING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTING: begin
        if (stop_fall) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (start_fall && start_ok) begin
          state_d = ST_COOKING;
        end else if (key_fall && key_ok) begin
          cnt_shift = 1'b1;
        end else begin
          state_d = ST_SETTING;
        end
      end
      ST_COOKING: begin
        // Door beats stop beats tick; a masked tick does not decrement.
        if (!door_closed || stop_fall) begin
          state_d = ST_PAUSED;
        end else if (tick_rise) begin
          cnt_dec = 1'b1;
          state_d = cnt_one_left ? ST_DONE : ST_COOKING;
        end else begin
          state_d = ST_COOKING;
        end
      end
      ST_PAUSED: begin
        if (stop_fall) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (start_fall && start_ok) begin
          state_d = ST_COOKING;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_DONE: begin
        if (stop_fall || key_fall || (tick_rise && beep_last)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    enablen = !((state_q == ST_IDLE) || (state_q == ST_SETTING));
    mag_on  = (state_q == ST_COOKING) && door_closed;
    done    = (state_q == ST_DONE);
`ifdef DONE_BEEP_EN
    beep    = (state_q == ST_DONE);
`else
    beep    = 1'b0;
`endif
  end

  bcd_countdown u_count (
    .clk      (clk),
    .clearn   (clearn),
    .clr      (cnt_clr),
    .shift    (cnt_shift),
    .d        (d_q),
    .dec      (cnt_dec),
    .min_o    (min_bcd),
    .tens_o   (sec_tens),
    .ones_o   (sec_ones),
    .zero     (cnt_zero),
    .one_left (cnt_one_left)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus random events vs a seconds-based model.
`timescale 1ns/1ps
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1hz = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       door_closed = 1'b1;
  logic       enablen, mag_on, done, beep;
  logic [3:0] min_bcd, sec_tens, sec_ones;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  timer_ctrl dut (
    .clk         (clk),
    .clearn      (clearn),
    .D           (D),
    .loadn       (loadn),
    .pgt_1hz     (pgt_1hz),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .enablen     (enablen),
    .mag_on      (mag_on),
    .min_bcd     (min_bcd),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .done        (done),
    .beep        (beep)
  );

`ifdef DONE_BEEP_EN
  localparam bit BEEP_MODE = 1'b1;
`else
  localparam bit BEEP_MODE = 1'b0;
`endif

  localparam int M_IDLE = 0, M_SETTING = 1, M_COOKING = 2, M_PAUSED = 3, M_DONE = 4;
  int   m_state = M_IDLE;
  int   m_secs  = 0;
  int   m_beeps = 0;
  logic m_door  = 1'b1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int m  = m_secs / 60;
    int st = (m_secs % 60) / 10;
    int so = m_secs % 10;
    chk({tag, ".min"},  min_bcd,  4'(m));
    chk({tag, ".tens"}, sec_tens, 4'(st));
    chk({tag, ".ones"}, sec_ones, 4'(so));
    chk({tag, ".mag"},  {3'b000, mag_on},  {3'b000, (m_state == M_COOKING) && m_door});
    chk({tag, ".done"}, {3'b000, done},    {3'b000, m_state == M_DONE});
    chk({tag, ".enn"},  {3'b000, enablen}, {3'b000, !((m_state == M_IDLE) || (m_state == M_SETTING))});
    chk({tag, ".beep"}, {3'b000, beep},    {3'b000, BEEP_MODE && (m_state == M_DONE)});
  endtask

  // Reference model: time kept as whole seconds, digits derived only for comparison.
  task automatic model_key(input int d);
    int st = (m_secs % 60) / 10;
    int so = m_secs % 10;
    if (m_state == M_IDLE || m_state == M_SETTING) begin
      if (d <= 9 && so <= 5) begin
        m_secs  = st * 60 + so * 10 + d;
        m_state = M_SETTING;
      end
    end else if (m_state == M_DONE) begin
      m_state = M_IDLE;
    end
  endtask

  task automatic model_start();
    if ((m_state == M_SETTING || m_state == M_PAUSED) && m_door && m_secs > 0)
      m_state = M_COOKING;
  endtask

  task automatic model_stop();
    if (m_state == M_COOKING) m_state = M_PAUSED;
    else if (m_state == M_SETTING || m_state == M_PAUSED) begin
      m_secs  = 0;
      m_state = M_IDLE;
    end else if (m_state == M_DONE) m_state = M_IDLE;
  endtask

  task automatic model_tick();
    if (m_state == M_COOKING && m_door) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin
        m_state = M_DONE;
        m_beeps = 0;
      end
    end else if (m_state == M_DONE && BEEP_MODE) begin
      m_beeps = m_beeps + 1;
      if (m_beeps == 3) m_state = M_IDLE;
    end
  endtask

  task automatic model_door(input logic v);
    m_door = v;
    if (!v && m_state == M_COOKING) m_state = M_PAUSED;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 clearn = 1'b0;
    #1;
    m_state = M_IDLE;
    m_secs  = 0;
    check_all(tag);
    wait_cyc(2);
    clearn = 1'b1;
    wait_cyc(2);
  endtask

  task automatic press_key(input logic [3:0] d);
    @(negedge clk);
    D = d;
    wait_cyc(1);
    loadn = 1'b0;
    wait_cyc(4);
    model_key(int'(d));
    check_all("key");
    loadn = 1'b1;
    wait_cyc(3);
  endtask

  task automatic press_start();
    @(negedge clk);
    startn = 1'b0;
    wait_cyc(4);
    model_start();
    check_all("start");
    startn = 1'b1;
    wait_cyc(3);
  endtask

  task automatic press_stop();
    @(negedge clk);
    stopn = 1'b0;
    wait_cyc(4);
    model_stop();
    check_all("stop");
    stopn = 1'b1;
    wait_cyc(3);
  endtask

  task automatic do_tick();
    @(negedge clk);
    pgt_1hz = 1'b1;
    wait_cyc(4);
    model_tick();
    check_all("tick");
    pgt_1hz = 1'b0;
    wait_cyc(3);
  endtask

  task automatic set_door(input logic v);
    @(negedge clk);
    door_closed = v;
    #1;
    model_door(v);
    check_all("door_now");
    wait_cyc(3);
    check_all("door_settled");
  endtask

  initial begin
    wait_cyc(2);
    check_all("por");
    clearn = 1'b1;
    wait_cyc(2);

    // Keys 1,3,0, start, five ticks: 1:30 -> 1:25.
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    press_start();
    for (int i = 0; i < 5; i++) do_tick();
    chk("r034.min", min_bcd, 4'd1);
    chk("r034.tens", sec_tens, 4'd2);
    chk("r034.ones", sec_ones, 4'd5);

    // Borrow across the minute, then the last second into DONE.
    do_reset("rst_a");
    press_key(4'd1); press_key(4'd0); press_key(4'd0);
    press_start();
    do_tick();
    chk("r035.tens", sec_tens, 4'd5);
    chk("r035.ones", sec_ones, 4'd9);
    do_reset("rst_b");
    press_key(4'd1);
    press_start();
    do_tick();
    chk("r035.done", {3'b000, done}, 4'd1);
    for (int i = 0; i < 3; i++) do_tick();
    press_stop();

    // Door opens on the same edge as a tick at 0:45.
    do_reset("rst_c");
    press_key(4'd4); press_key(4'd5);
    press_start();
    @(negedge clk);
    pgt_1hz = 1'b1;
    @(posedge clk);
    #1 door_closed = 1'b0;
    #1;
    model_door(1'b0);
    check_all("coinc_now");
    wait_cyc(4);
    model_tick();
    check_all("coinc_held");
    pgt_1hz = 1'b0;
    wait_cyc(3);
    set_door(1'b1);
    press_start();
    do_tick();
    chk("r036.ones", sec_ones, 4'd4);

    // 0:07 rejects key 8 (would give 0:78), then stop clears.
    do_reset("rst_d");
    press_key(4'd7); press_key(4'd8);
    chk("r037.ones", sec_ones, 4'd7);
    press_stop();

    // Asynchronous reset mid-cook at 2:10.
    do_reset("rst_e");
    press_key(4'd2); press_key(4'd1); press_key(4'd0);
    press_start();
    chk("r039.mag_pre", {3'b000, mag_on}, 4'd1);
    do_reset("r039.async");

    // Random event mix.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 6))
        0, 1: press_key(4'($urandom_range(0, 11)));
        2:    press_start();
        3:    press_stop();
        4, 5: do_tick();
        default: set_door(~door_closed);
      endcase
    end
    set_door(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
